// File: rtl/synch_pkg.sv
// Shared constants and the counter-width helper for multi_sample_synch and its IPL users.
package synch_pkg;

  localparam int IPL_WIDTH = 3;
  localparam logic [IPL_WIDTH-1:0] IPL_IDLE = 3'b111;
  localparam int GLITCH_CNT_W = 16;

  // Counter must be able to hold MATCH_COUNT itself, since it saturates there.
  function automatic int cnt_width(input int match_count);
    return $clog2(match_count + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Metastability shift chain: shifts every clock, synchronous active-low reset to RESET_VALUE.
module sync_chain #(
  parameter int WIDTH = 3,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= RESET_VALUE;
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dout = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/multi_sample_synch.sv
// Synchronises an async bus and updates DOUT only after MATCH_COUNT equal qualified samples.
// Optional abort counter (GLITCH_CLR/GLITCH_CNT) is built with MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN.
module multi_sample_synch
  import synch_pkg::*;
#(
  parameter int WIDTH = IPL_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int MATCH_COUNT = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    SAMPLE_EN,
  input  logic [WIDTH-1:0]        DIN_ASYNC,
  output logic [WIDTH-1:0]        DOUT,
  output logic                    DOUT_CHANGED,
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
  input  logic                    GLITCH_CLR,
  output logic [GLITCH_CNT_W-1:0] GLITCH_CNT,
`endif
  output logic                    STABLE
);

  localparam int CW = cnt_width(MATCH_COUNT);
  localparam logic [CW-1:0] MC = CW'(MATCH_COUNT);

  if (WIDTH < 1) begin : g_bad_width
    $error("multi_sample_synch: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("multi_sample_synch: SYNC_STAGES must be >= 2");
  end
  if (MATCH_COUNT < 1) begin : g_bad_match_count
    $error("multi_sample_synch: MATCH_COUNT must be >= 1");
  end

  logic [WIDTH-1:0] w_sync_out;
  logic [WIDTH-1:0] w_next_cand;
  logic [CW-1:0]    w_next_cnt;
  logic             w_update;

  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_changed;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_chain (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_din   (DIN_ASYNC),
    .o_dout  (w_sync_out)
  );

  always_comb begin
    w_next_cand = r_cand;
    w_next_cnt  = r_cnt;
    if (SAMPLE_EN) begin
      if (w_sync_out != r_cand) begin
        w_next_cand = w_sync_out;
        w_next_cnt  = CW'(1);
      end else if (r_cnt < MC) begin
        w_next_cnt = r_cnt + 1'b1;
      end
    end
  end

  // Update decision looks at the values being written so DOUT moves on the qualifying edge.
  assign w_update = SAMPLE_EN && (w_next_cnt == MC) && (w_next_cand != r_dout);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_cand    <= RESET_VALUE;
      r_cnt     <= MC;
      r_dout    <= RESET_VALUE;
      r_changed <= 1'b0;
    end else begin
      r_cand    <= w_next_cand;
      r_cnt     <= w_next_cnt;
      r_changed <= w_update;
      if (w_update) r_dout <= w_next_cand;
    end
  end

  assign DOUT         = r_dout;
  assign DOUT_CHANGED = r_changed;
  assign STABLE       = (r_cnt == MC) && (r_cand == r_dout);

`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;
  logic                    w_abort;

  // A pending change is abandoned when a different value displaces it before it matured.
  assign w_abort = SAMPLE_EN && (w_sync_out != r_cand) && (r_cand != r_dout) && (r_cnt < MC);

  always_ff @(posedge CLK) begin
    if (!RESET_N || GLITCH_CLR) begin
      r_glitch_cnt <= '0;
    end else if (w_abort && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign GLITCH_CNT = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_multi_sample_synch.sv
// Directed bench for multi_sample_synch: default instance plus a MATCH_COUNT=1, SYNC_STAGES=3 instance.
module tb_multi_sample_synch;
  import synch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, en1;
  logic [2:0] din, din1;
  logic [2:0] dout, dout1;
  logic       chg, chg1, stb, stb1;
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
  logic        gclr, gclr1;
  logic [15:0] gcnt, gcnt1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  multi_sample_synch dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .SAMPLE_EN    (en),
    .DIN_ASYNC    (din),
    .DOUT         (dout),
    .DOUT_CHANGED (chg),
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
    .GLITCH_CLR   (gclr),
    .GLITCH_CNT   (gcnt),
`endif
    .STABLE       (stb)
  );

  multi_sample_synch #(
    .WIDTH       (3),
    .SYNC_STAGES (3),
    .MATCH_COUNT (1)
  ) dut1 (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .SAMPLE_EN    (en1),
    .DIN_ASYNC    (din1),
    .DOUT         (dout1),
    .DOUT_CHANGED (chg1),
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
    .GLITCH_CLR   (gclr1),
    .GLITCH_CNT   (gcnt1),
`endif
    .STABLE       (stb1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every DOUT_CHANGED pulse must retire the oldest expected value; a spurious pulse compares against ~DOUT.
  always @(negedge clk) begin
    logic [2:0] e0, e1;
    if (chg === 1'b1) begin
      e0 = (q0.size() != 0) ? q0.pop_front() : ~dout;
      check("sb_dut", 32'(dout), 32'(e0));
    end
    if (chg1 === 1'b1) begin
      e1 = (q1.size() != 0) ? q1.pop_front() : ~dout1;
      check("sb_dut1", 32'(dout1), 32'(e1));
    end
  end

  initial begin
    logic [2:0] vals [4];
    logic [2:0] prev1;
    vals[0] = 3'b010; vals[1] = 3'b001; vals[2] = 3'b110; vals[3] = 3'b111;

    rst_n = 1'b0; en = 1'b1; en1 = 1'b1; din = 3'b010; din1 = 3'b010;
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
    gclr = 1'b0; gclr1 = 1'b0;
`endif

    // Reset held for three edges with a non-idle input.
    step(3);
    check("reset_dout", 32'(dout), 32'(3'b111));
    check("reset_stable", 32'(stb), 32'(1'b1));
    check("reset_changed", 32'(chg), 32'(1'b0));
    check("reset_dout1", 32'(dout1), 32'(3'b111));
    check("reset_stable1", 32'(stb1), 32'(1'b1));
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
    check("reset_gcnt", 32'(gcnt), 32'(16'h0000));
    check("reset_gcnt1", 32'(gcnt1), 32'(16'h0000));
`endif
    din = 3'b111; din1 = 3'b111; rst_n = 1'b1;
    step(4);
    check("idle_dout", 32'(dout), 32'(3'b111));
    check("idle_stable", 32'(stb), 32'(1'b1));

    // One-sample glitch that returns to the DOUT value.
    din = 3'b100;
    step(1);
    din = 3'b111;
    step(2);
    check("glitch_pending", 32'(stb), 32'(1'b0));
    check("glitch_dout_a", 32'(dout), 32'(3'b111));
    step(1);
    check("glitch_dout_b", 32'(dout), 32'(3'b111));
    check("glitch_nochg", 32'(chg), 32'(1'b0));
    step(1);
    check("glitch_stable", 32'(stb), 32'(1'b1));
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
    check("glitch_gcnt", 32'(gcnt), 32'(16'h0001));
`endif

    // Basic latency: change before edge 1, DOUT at edge 4, pulse during the following cycle.
    din = 3'b101; q0.push_back(3'b101);
    step(3);
    check("lat_e3_dout", 32'(dout), 32'(3'b111));
    check("lat_e3_stable", 32'(stb), 32'(1'b0));
    step(1);
    check("lat_e4_dout", 32'(dout), 32'(3'b101));
    check("lat_e4_chg", 32'(chg), 32'(1'b1));
    step(1);
    check("lat_e5_chg", 32'(chg), 32'(1'b0));
    check("lat_e5_stable", 32'(stb), 32'(1'b1));

    // Strobe on edges 3,7,11: sync_out settles after edge 2, so DOUT moves at edge 7 only.
    din = 3'b011; q0.push_back(3'b011);
    for (int i = 1; i <= 10; i++) begin
      en = ((i % 4) == 3);
      step(1);
      check("qual_dout", 32'(dout), (i >= 7) ? 32'(3'b011) : 32'(3'b101));
      check("qual_chg", 32'(chg), (i == 7) ? 32'd1 : 32'd0);
    end
    en = 1'b1;

    // Reset while a change is half-counted.
    din = 3'b110;
    step(3);
    check("midrst_pending", 32'(stb), 32'(1'b0));
    rst_n = 1'b0; din = 3'b111;
    step(1);
    check("midrst_dout", 32'(dout), 32'(3'b111));
    check("midrst_chg", 32'(chg), 32'(1'b0));
    check("midrst_stable", 32'(stb), 32'(1'b1));
`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
    check("midrst_gcnt", 32'(gcnt), 32'(16'h0000));
`endif
    rst_n = 1'b1;
    step(4);
    check("postrst_dout", 32'(dout), 32'(3'b111));
    check("postrst_stable", 32'(stb), 32'(1'b1));

    // Pure synchroniser: three chain stages then one sample, every change pulses.
    prev1 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      din1 = vals[k]; q1.push_back(vals[k]);
      step(3);
      check("mc1_e3_dout", 32'(dout1), 32'(prev1));
      check("mc1_e3_chg", 32'(chg1), 32'(1'b0));
      step(1);
      check("mc1_e4_dout", 32'(dout1), 32'(vals[k]));
      check("mc1_e4_chg", 32'(chg1), 32'(1'b1));
      step(1);
      check("mc1_e5_chg", 32'(chg1), 32'(1'b0));
      check("mc1_e5_stable", 32'(stb1), 32'(1'b1));
      prev1 = vals[k];
    end

`ifdef MULTI_SAMPLE_SYNCH_GLITCH_STATS_EN
    // Alternating non-DOUT values abort on every sample after the first, plus the return to idle.
    gclr = 1'b1;
    step(1);
    gclr = 1'b0;
    check("stats_clr", 32'(gcnt), 32'(16'h0000));
    for (int i = 0; i < 65534; i++) begin
      din = i[0] ? 3'b010 : 3'b100;
      step(1);
    end
    din = 3'b111;
    step(4);
    check("stats_fffe", 32'(gcnt), 32'(16'hFFFE));
    check("stats_dout", 32'(dout), 32'(3'b111));
    din = 3'b100;
    step(1);
    din = 3'b010;
    step(1);
    din = 3'b111;
    step(4);
    check("stats_sat", 32'(gcnt), 32'(16'hFFFF));
    gclr = 1'b1; din = 3'b100;
    step(1);
    din = 3'b111;
    step(5);
    gclr = 1'b0;
    check("stats_clr_prio", 32'(gcnt), 32'(16'h0000));
`endif

    step(2);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
